// File: rtl/rj_counter_param.sv
// Parametrised ring/Johnson shift counter with enable, direction, load, position index and wrap pulse.
// Optional illegal-state self-correction on step cycles when RJ_SELF_CORRECT_EN is defined.
module rj_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rj,
    input  logic                                  en,
    input  logic                                  dir,
    input  logic                                  load,
    input  logic [WIDTH-1:0]                      load_val,
    output logic [WIDTH-1:0]                      q,
    output logic [$clog2(2*WIDTH)-1:0]            idx,
    output logic                                  wrap,
    output logic                                  err
);

    localparam int IDX_W = $clog2(2*WIDTH);

    logic             mode_q;
    logic [WIDTH-1:0] q_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] idx_last;
    logic             mode_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    function automatic logic [WIDTH-1:0] seed(input logic m);
        return m ? '0 : WIDTH'(1);
    endfunction

    function automatic int popcount(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // Johnson legality: the pattern may contain at most one 0/1 boundary.
    function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
        int t;
        t = 0;
        for (int i = 0; i < WIDTH-1; i++) t += int'(v[i] != v[i+1]);
        return m ? (t <= 1) : (popcount(v) == 1);
    endfunction

    function automatic logic [IDX_W-1:0] decode(input logic [WIDTH-1:0] v, input logic m);
        int r;
        r = 0;
        if (is_legal(v, m)) begin
            if (!m) begin
                for (int i = 0; i < WIDTH; i++) if (v[i]) r = i;
            end else if (v == '0) begin
                r = 0;
            end else if (v[0]) begin
                r = popcount(v);
            end else begin
                r = 2*WIDTH - popcount(v);
            end
        end
        return IDX_W'(r);
    endfunction

    assign idx_last = mode_q ? IDX_W'(2*WIDTH-1) : IDX_W'(WIDTH-1);

    always_comb begin
        mode_nxt = mode_q;
        q_nxt    = q;
        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            q_nxt   = load_val;
            idx_nxt = decode(load_val, mode_q);
        end else if (rj != mode_q) begin
            mode_nxt = rj;
            q_nxt    = seed(rj);
            idx_nxt  = '0;
        end else if (en) begin
`ifdef RJ_SELF_CORRECT_EN
            if (!is_legal(q, mode_q)) begin
                q_nxt   = seed(mode_q);
                idx_nxt = '0;
                err_nxt = 1'b1;
            end else
`endif
            if (!dir) begin
                q_nxt    = {q[WIDTH-2:0], q[WIDTH-1] ^ mode_q};
                wrap_nxt = (idx == idx_last);
                idx_nxt  = wrap_nxt ? '0 : idx + IDX_W'(1);
            end else begin
                q_nxt    = {q[0] ^ mode_q, q[WIDTH-1:1]};
                wrap_nxt = (idx == '0);
                idx_nxt  = wrap_nxt ? idx_last : idx - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= rj;
            q      <= seed(rj);
            idx    <= '0;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            mode_q <= mode_nxt;
            q      <= q_nxt;
            idx    <= idx_nxt;
            wrap   <= wrap_nxt;
            err    <= err_nxt;
        end
    end

endmodule
